// File: rtl/bch15_7_pkg.sv
// Shared constants, status codes and parity function for the (15,7) BCH encoder/decoder pair.
package bch15_7_pkg;

  localparam int unsigned N = 15;
  localparam int unsigned K = 7;
  localparam int unsigned R = 8;

  // Parity-check matrix columns. Bit k of each column is syndrome bit k.
  localparam logic [R-1:0] H_COL [0:N-1] = '{
    8'hD1, 8'h73, 8'hE6, 8'h1D, 8'h3A, 8'h74, 8'hE8,
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
  };

  typedef enum logic [1:0] {
    ST_CLEAN = 2'b00,
    ST_CORR1 = 2'b01,
    ST_CORR2 = 2'b10,
    ST_FAIL  = 2'b11
  } status_e;

  function automatic logic [R-1:0] bch_parity(input logic [K-1:0] d);
    logic [R-1:0] p;
    p[0] = d[0] ^ d[1] ^ d[3];
    p[1] = d[1] ^ d[2] ^ d[4];
    p[2] = d[2] ^ d[3] ^ d[5];
    p[3] = d[3] ^ d[4] ^ d[6];
    p[4] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[5];
    p[5] = d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[6];
    p[6] = d[0] ^ d[1] ^ d[2] ^ d[5] ^ d[6];
    p[7] = d[0] ^ d[2] ^ d[6];
    return p;
  endfunction

endpackage

// File: rtl/bch15_7_err_locate.sv
// Combinational error locator: maps an 8-bit syndrome to a 15-bit flip mask and status.
module bch15_7_err_locate
  import bch15_7_pkg::*;
(
  input  logic [R-1:0] syn,
  output logic [N-1:0] err_mask,
  output status_e      status
);

  logic [N-1:0] mask1;
  logic [N-1:0] mask2;
  logic         hit1;
  logic         hit2;

  always_comb begin
    mask1 = '0;
    mask2 = '0;
    hit1  = 1'b0;
    hit2  = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (syn == H_COL[j]) begin
        mask1[j] = 1'b1;
        hit1     = 1'b1;
      end
    end
    // d_min = 5 guarantees at most one pair can match a non-zero syndrome.
    for (int unsigned a = 0; a < N - 1; a++) begin
      for (int unsigned b = a + 1; b < N; b++) begin
        if (syn == (H_COL[a] ^ H_COL[b])) begin
          mask2[a] = 1'b1;
          mask2[b] = 1'b1;
          hit2     = 1'b1;
        end
      end
    end

    err_mask = '0;
    status   = ST_FAIL;
    if (syn == '0) begin
      status = ST_CLEAN;
    end else if (hit1) begin
      err_mask = mask1;
      status   = ST_CORR1;
    end else if (hit2) begin
      err_mask = mask2;
      status   = ST_CORR2;
    end
  end

endmodule

// File: rtl/bch15_7_decoder.sv
// Two-stage stallable (15,7) BCH decoder: S1 registers data and syndrome, S2 corrects up to
// two errors. Saturating correction/failure counters for link monitoring.
module bch15_7_decoder
  import bch15_7_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [K-1:0]     out_data,
  output logic [1:0]       out_status,
  input  logic             cnt_clear,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  logic         s1_valid_q;
  logic [K-1:0] s1_data_q;
  logic [R-1:0] s1_syn_q;
  logic         s2_load;
  logic         accept;
  logic [N-1:0] err_mask;
  status_e      err_status;
  logic         corr_hit;
  logic         fail_hit;
  logic         unused_parity_mask;

  assign s2_load  = !out_valid | out_ready;
  assign in_ready = !s1_valid_q | s2_load;
  assign accept   = in_valid & in_ready;

  // Parity positions are only needed for the syndrome, so S1 keeps data bits alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_data_q  <= in_word[K-1:0];
      s1_syn_q   <= in_word[N-1:K] ^ bch_parity(in_word[K-1:0]);
    end else if (s2_load) begin
      s1_valid_q <= 1'b0;
    end
  end

  bch15_7_err_locate u_err_locate (
    .syn      (s1_syn_q),
    .err_mask (err_mask),
    .status   (err_status)
  );

  assign unused_parity_mask = ^err_mask[N-1:K];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_status <= 2'b00;
    end else if (s2_load) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) begin
        out_data   <= s1_data_q ^ err_mask[K-1:0];
        out_status <= err_status;
      end
    end
  end

  assign corr_hit = s2_load & s1_valid_q & ((err_status == ST_CORR1) | (err_status == ST_CORR2));
  assign fail_hit = s2_load & s1_valid_q & (err_status == ST_FAIL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_cnt <= '0;
      fail_cnt <= '0;
    end else if (cnt_clear) begin
      corr_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      if (corr_hit && (corr_cnt != '1)) corr_cnt <= corr_cnt + CNT_W'(1);
      if (fail_hit && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bch15_7_decoder.sv
// Self-checking bench: directed plan vectors plus randomized traffic against a brute-force
// nearest-codeword reference model.
module tb_bch15_7_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_data;
  logic [1:0]  out_status;
  logic        cnt_clear;
  logic [15:0] corr_cnt;
  logic [15:0] fail_cnt;

  logic        in_ready_s;
  logic        out_valid_s;
  logic [6:0]  out_data_s;
  logic [1:0]  out_status_s;
  logic [1:0]  corr_cnt_s;
  logic [1:0]  fail_cnt_s;

  bch15_7_decoder #(.CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_status (out_status),
    .cnt_clear  (cnt_clear),
    .corr_cnt   (corr_cnt),
    .fail_cnt   (fail_cnt)
  );

  bch15_7_decoder #(.CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready_s),
    .in_word    (in_word),
    .out_valid  (out_valid_s),
    .out_ready  (out_ready),
    .out_data   (out_data_s),
    .out_status (out_status_s),
    .cnt_clear  (cnt_clear),
    .corr_cnt   (corr_cnt_s),
    .fail_cnt   (fail_cnt_s)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  int          corr_m = 0;
  int          fail_m = 0;
  logic        stalled = 1'b0;
  logic [8:0]  prev_out = '0;

  function automatic logic [7:0] ref_parity(input logic [6:0] d);
    logic [7:0] p;
    p[0] = d[0] ^ d[1] ^ d[3];
    p[1] = d[1] ^ d[2] ^ d[4];
    p[2] = d[2] ^ d[3] ^ d[5];
    p[3] = d[3] ^ d[4] ^ d[6];
    p[4] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[5];
    p[5] = d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[6];
    p[6] = d[0] ^ d[1] ^ d[2] ^ d[5] ^ d[6];
    p[7] = d[0] ^ d[2] ^ d[6];
    return p;
  endfunction

  function automatic logic is_codeword(input logic [14:0] w);
    return w[14:7] == ref_parity(w[6:0]);
  endfunction

  // Nearest codeword within distance 2; returns {status, data}.
  function automatic logic [8:0] ref_decode(input logic [14:0] r);
    logic [14:0] c;
    if (is_codeword(r)) return {2'b00, r[6:0]};
    for (int i = 0; i < 15; i++) begin
      c = r ^ (15'd1 << i);
      if (is_codeword(c)) return {2'b01, c[6:0]};
    end
    for (int i = 0; i < 14; i++) begin
      for (int j = i + 1; j < 15; j++) begin
        c = r ^ (15'd1 << i) ^ (15'd1 << j);
        if (is_codeword(c)) return {2'b10, c[6:0]};
      end
    end
    return {2'b11, r[6:0]};
  endfunction

  function automatic logic [14:0] rand_word();
    logic [6:0]  d;
    logic [14:0] w;
    int          nerr;
    d    = 7'($urandom);
    w    = {ref_parity(d), d};
    nerr = int'($urandom_range(0, 4));
    if (nerr == 4) return 15'($urandom);
    for (int e = 0; e < nerr; e++) w[$urandom_range(0, 14)] ^= 1'b1;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_counters();
    check("corr_cnt", 32'(corr_cnt), 32'(corr_m));
    check("fail_cnt", 32'(fail_cnt), 32'(fail_m));
    check("corr_cnt_sat", 32'(corr_cnt_s), 32'(corr_m > 3 ? 3 : corr_m));
    check("fail_cnt_sat", 32'(fail_cnt_s), 32'(fail_m > 3 ? 3 : fail_m));
  endtask

  // Called at a negedge after inputs are set; samples, then advances one clock.
  task automatic cycle(output logic acc);
    logic [8:0] e;
    #1;
    if (stalled) check("stall_hold", 32'({out_valid, out_status, out_data}), 32'({1'b1, prev_out}));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("out_data", 32'(out_data), 32'(e[6:0]));
        check("out_status", 32'(out_status), 32'(e[8:7]));
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e = ref_decode(in_word);
      exp_q.push_back(e);
      if (e[8:7] == 2'b01 || e[8:7] == 2'b10) corr_m++;
      else if (e[8:7] == 2'b11) fail_m++;
    end
    stalled  = out_valid && !out_ready;
    prev_out = {out_status, out_data};
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_word(input logic [14:0] w);
    logic acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_word  = w;
    for (int t = 0; t < 50 && !acc; t++) cycle(acc);
    if (!acc) check("accept_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    logic acc;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) cycle(acc);
    for (int t = 0; t < 2; t++) cycle(acc);
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check_counters();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [14:0] w;
    logic [14:0] bp_words[4];
    logic        pending;
    int          sent;

    rst = 1'b1; in_valid = 1'b0; in_word = '0; out_ready = 1'b0; cnt_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_status", 32'(out_status), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check_counters();
    @(negedge clk);

    // Clean word and two-edge latency.
    out_ready = 1'b1; in_valid = 1'b1; in_word = 15'h72D5;
    cycle(acc);
    in_valid = 1'b0;
    #1 check("lat_s1_only", 32'(out_valid), 32'd0);
    cycle(acc);
    #1;
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("clean_data", 32'(out_data), 32'h55);
    check("clean_status", 32'(out_status), 32'd0);
    drain();

    push_word(15'h72DD);
    drain();
    check("single_corr_cnt", 32'(corr_cnt), 32'd1);

    push_word(15'h32D4);
    drain();
    check("double_corr_cnt", 32'(corr_cnt), 32'd2);

    w = 15'($urandom);
    for (int t = 0; t < 1000 && ref_decode(w)[8:7] != 2'b11; t++) w = 15'($urandom);
    push_word(w);
    drain();
    check("fail_cnt_one", 32'(fail_cnt), 32'd1);

    // Backpressure: four words streamed, consumer stalled for three cycles.
    for (int i = 0; i < 4; i++) bp_words[i] = rand_word();
    sent = 0;
    for (int c = 0; c < 20 && (sent < 4 || exp_q.size() > 0); c++) begin
      out_ready = (c >= 3);
      in_valid  = (sent < 4);
      in_word   = bp_words[sent < 4 ? sent : 3];
      if (c == 2) begin
        #1 check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_two_accepted", 32'(sent), 32'd2);
      end
      cycle(acc);
      if (acc) sent++;
    end
    drain();

    // Randomized traffic with random gaps and backpressure.
    pending = 1'b0;
    sent    = 0;
    for (int c = 0; c < 1500 && sent < 300; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && $urandom_range(0, 3) != 0) begin
        pending = 1'b1;
        in_word = rand_word();
      end
      in_valid = pending;
      cycle(acc);
      if (acc) begin
        pending = 1'b0;
        sent++;
      end
    end
    in_valid = 1'b0;
    drain();

    // Clear coincides with an increment: clear wins.
    out_ready = 1'b1; in_valid = 1'b1; in_word = 15'h72DD;
    cycle(acc);
    in_valid = 1'b0; cnt_clear = 1'b1;
    cycle(acc);
    cnt_clear = 1'b0;
    corr_m = 0; fail_m = 0;
    #1;
    check("clear_corr", 32'(corr_cnt), 32'd0);
    check("clear_fail", 32'(fail_cnt), 32'd0);
    check("clear_corr_sat", 32'(corr_cnt_s), 32'd0);
    drain();
    corr_m = 0; fail_m = 0;
    check_counters();

    // Reset with two words in flight.
    out_ready = 1'b0; in_valid = 1'b1;
    in_word = rand_word();
    cycle(acc);
    in_word = rand_word();
    cycle(acc);
    in_valid = 1'b0;
    rst = 1'b1;
    #1 check("midrst_out_valid", 32'(out_valid), 32'd0);
    exp_q.delete();
    corr_m = 0; fail_m = 0; stalled = 1'b0;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      #1 check("postrst_quiet", 32'(out_valid), 32'd0);
      cycle(acc);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bch15_7_decoder.md
Name: bch15_7_decoder

Overview:
- Receive-side companion to the (15,7) systematic encoder. Accepts 15-bit received words through a valid/ready handshake and computes the 8-bit syndrome.
- Corrects up to 2 bit errors (d_min = 5) and delivers the 7 corrected data bits with a status code through a second valid/ready handshake.
- Two-stage stallable pipeline, plus saturating correction/failure statistics counters for the link monitor.

Parameters:
- CNT_W, 16, width of each saturating statistics counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_word valid.
- in_ready  out  1  decoder can accept in_word this cycle.
- in_word  in  15  received codeword; [6:0] data, [14:7] parity, same bit order as the encoder.
- out_valid  out  1  out_data/out_status valid.
- out_ready  in  1  consumer accepts the output this cycle.
- out_data  out  7  corrected data.
- out_status  out  2  00 clean, 01 one bit corrected, 10 two bits corrected, 11 uncorrectable.
- cnt_clear  in  1  synchronous clear of both counters.
- corr_cnt  out  CNT_W  words with status 01 or 10 (saturating).
- fail_cnt  out  CNT_W  words with status 11 (saturating).

Behaviour:
- Reset (async assert, sync release):
  - all valid flags 0, out_data 0, out_status 00, counters 0.
  - in_ready is 1 on the first cycle after release.
- Parity functions p[k], with k = 0..7 mapping to codeword bit 7+k:
  - p0 = d0^d1^d3
  - p1 = d1^d2^d4
  - p2 = d2^d3^d5
  - p3 = d3^d4^d6
  - p4 = d0^d1^d3^d4^d5
  - p5 = d1^d2^d4^d5^d6
  - p6 = d0^d1^d2^d5^d6
  - p7 = d0^d2^d6
- Syndrome: s[k] = r[7+k] ^ p[k](r[6:0]).
- H columns (8-bit, bit k = s[k]):
  - data bits 0..6 = D1, 73, E6, 1D, 3A, 74, E8 (hex).
  - parity bit 7+k = one-hot(k).
- Stage 1 (S1): on an accepted input (in_valid & in_ready), register r and s; set s1_valid.
- Stage 2 (S2): error location from the S1 registers.
  - s == 0 -> status 00.
  - s equals exactly one column j -> flip bit j, status 01.
  - s equals col(a)^col(b) for a unique pair a<b -> flip bits a and b, status 10.
  - otherwise status 11; out_data = r[6:0] unmodified.
  - Corrections on parity bits still report 01/10, but data is unchanged.
  - Registered into out_data/out_status; set out_valid.
- Pipeline advance:
  - S2 loads when !out_valid | out_ready.
  - S1 loads/advances when !s1_valid | (S2 loads).
  - in_ready = !s1_valid | (S2 loads); combinational from out_ready, no combinational path from in_valid.
- Latency and throughput: 2 cycles from input accept to out_valid; full throughput of 1 word/cycle when out_ready is held high.
- Stall: while out_valid & !out_ready, out_data/out_status/out_valid are held stable and no word is dropped or duplicated.
- Counters:
  - Increment on the cycle S2 loads a word with the relevant status.
  - Saturate at 2^CNT_W-1 (no wrap).
  - cnt_clear has priority over a same-cycle increment; counters read 0 the next cycle.
- Reset mid-operation clears both pipeline stages; in-flight words are discarded.

Decomposition:
- Package bch15_7_pkg holds:
  - N=15, K=7, R=8.
  - H column constant array H_COL[0:14].
  - status enum {ST_CLEAN, ST_CORR1, ST_CORR2, ST_FAIL}.
  - parity function shared with the encoder.
- One natural sub-module: bch15_7_err_locate.
  - Purely combinational: syndrome in, 15-bit error mask and status out.
  - Implemented by comparing against 15 single columns and 105 pair XORs.
  - Instantiated in S2.

Test Plan:
- Clean word: in_word=0x72D5 (data 0x55) -> two cycles later out_data=0x55, status 00, counters unchanged.
- Single error: in_word=0x72DD (bit 3 flipped, s=0x1D) -> out_data=0x55, status 01, corr_cnt=1.
- Double error: in_word=0x32D4 (bits 0,14 flipped, s=0x51) -> out_data=0x55, status 10, corr_cnt increments.
- Uncorrectable:
  - Stimulus: bench picks r with a syndrome outside the 121-entry set computed from H_COL.
  - Response: status 11, out_data=r[6:0], fail_cnt=1.
- Back-to-back with backpressure:
  - Stimulus: 4 words streamed, out_ready held low for 3 cycles.
  - Response: in_ready drops after 2 words, output held stable, all 4 emitted in order, no loss.
- Corner cases:
  - Counters preset near saturation with CNT_W=2 -> stick at 3.
  - cnt_clear with a simultaneous increment -> 0.
  - rst asserted with 2 words in flight -> out_valid=0 immediately, nothing emitted after release.
